// File: rtl/pingpong_sram_ctrl.sv
// Ping-pong controller for two single-port SRAM banks: one bank fills from the
// input stream while the other, already full, drains in address order to the output.
module pingpong_sram_ctrl #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned OFIFO_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              CEN_EVEN,
   output logic              WEN_EVEN,
   output logic [ADDR_W-1:0] A_EVEN,
   output logic              CEN_ODD,
   output logic              WEN_ODD,
   output logic [ADDR_W-1:0] A_ODD,
   output logic [DATA_W-1:0] D,
   input  logic [DATA_W-1:0] Q_EVEN,
   input  logic [DATA_W-1:0] Q_ODD
);

   typedef enum logic {BANK_EVEN = 1'b0, BANK_ODD = 1'b1} bank_t;

   localparam int unsigned       PTR_W     = $clog2(OFIFO_DEPTH);
   localparam int unsigned       CNT_W     = PTR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  FIFO_CAP  = CNT_W'(OFIFO_DEPTH);

   bank_t             wr_bank, rd_bank;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic [1:0]        bank_full;

   // Read tag pipeline: p1 = pins registered, p2 = SRAM has sampled, push next edge.
   logic              p1_valid, p2_valid;
   bank_t             p1_tag, p2_tag;

   logic [DATA_W-1:0] fifo_mem [OFIFO_DEPTH];
   logic [PTR_W-1:0]  fifo_rptr, fifo_wptr;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W:0]    occupancy;

   logic accept, issue, push, pop;

   always_comb begin
      in_ready  = !bank_full[wr_bank];
      accept    = in_valid && in_ready;
      occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, p1_valid} + {{CNT_W{1'b0}}, p2_valid};
      issue     = bank_full[rd_bank] && (occupancy < {1'b0, FIFO_CAP})
                  && !(accept && (wr_bank == rd_bank));
      push      = p2_valid;
      out_valid = (fifo_count != '0);
      out_data  = fifo_mem[fifo_rptr];
      pop       = out_valid && out_ready;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         CEN_EVEN   <= 1'b1;
         WEN_EVEN   <= 1'b1;
         A_EVEN     <= '0;
         CEN_ODD    <= 1'b1;
         WEN_ODD    <= 1'b1;
         A_ODD      <= '0;
         D          <= '0;
         wr_bank    <= BANK_EVEN;
         rd_bank    <= BANK_EVEN;
         wr_addr    <= '0;
         rd_addr    <= '0;
         bank_full  <= '0;
         p1_valid   <= 1'b0;
         p2_valid   <= 1'b0;
         p1_tag     <= BANK_EVEN;
         p2_tag     <= BANK_EVEN;
         fifo_rptr  <= '0;
         fifo_wptr  <= '0;
         fifo_count <= '0;
         for (int unsigned i = 0; i < OFIFO_DEPTH; i++) fifo_mem[i] <= '0;
      end else begin
         CEN_EVEN <= 1'b1;
         WEN_EVEN <= 1'b1;
         CEN_ODD  <= 1'b1;
         WEN_ODD  <= 1'b1;

         if (accept) begin
            if (wr_bank == BANK_EVEN) begin
               CEN_EVEN <= 1'b0;
               WEN_EVEN <= 1'b0;
               A_EVEN   <= wr_addr;
            end else begin
               CEN_ODD  <= 1'b0;
               WEN_ODD  <= 1'b0;
               A_ODD    <= wr_addr;
            end
            D       <= in_data;
            wr_addr <= wr_addr + ADDR_W'(1);
            if (wr_addr == LAST_ADDR) begin
               bank_full[wr_bank] <= 1'b1;
               wr_bank <= (wr_bank == BANK_EVEN) ? BANK_ODD : BANK_EVEN;
            end
         end

         // issue never targets wr_bank while accepting, so the pin writes cannot collide
         if (issue) begin
            if (rd_bank == BANK_EVEN) begin
               CEN_EVEN <= 1'b0;
               A_EVEN   <= rd_addr;
            end else begin
               CEN_ODD  <= 1'b0;
               A_ODD    <= rd_addr;
            end
            rd_addr <= rd_addr + ADDR_W'(1);
            if (rd_addr == LAST_ADDR) begin
               bank_full[rd_bank] <= 1'b0;
               rd_bank <= (rd_bank == BANK_EVEN) ? BANK_ODD : BANK_EVEN;
            end
         end

         p1_valid <= issue;
         p1_tag   <= rd_bank;
         p2_valid <= p1_valid;
         p2_tag   <= p1_tag;

         if (push) begin
            fifo_mem[fifo_wptr] <= (p2_tag == BANK_ODD) ? Q_ODD : Q_EVEN;
            fifo_wptr           <= fifo_wptr + PTR_W'(1);
         end
         if (pop) fifo_rptr <= fifo_rptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_pingpong_sram_ctrl.sv
// Bench for pingpong_sram_ctrl: behavioural SRAM banks, a queue-based ordering model
// and a per-cycle monitor that also tracks which SRAM words hold unread data.
module tb_pingpong_sram_ctrl;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int DP = 16;
   localparam int FD = 4;

   logic          CLK = 1'b0;
   logic          RESET_N = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready = 1'b0;
   logic          CEN_EVEN, WEN_EVEN, CEN_ODD, WEN_ODD;
   logic [AW-1:0] A_EVEN, A_ODD;
   logic [DW-1:0] D;
   logic [DW-1:0] Q_EVEN = '0;
   logic [DW-1:0] Q_ODD = '0;

   pingpong_sram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .OFIFO_DEPTH(FD)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .CEN_EVEN(CEN_EVEN), .WEN_EVEN(WEN_EVEN), .A_EVEN(A_EVEN),
      .CEN_ODD(CEN_ODD), .WEN_ODD(WEN_ODD), .A_ODD(A_ODD),
      .D(D), .Q_EVEN(Q_EVEN), .Q_ODD(Q_ODD)
   );

   always #5 CLK = ~CLK;

   // behavioural sram_w16 macros
   logic [DW-1:0] mem_even [DP];
   logic [DW-1:0] mem_odd  [DP];
   always @(posedge CLK) begin
      if (!CEN_EVEN) begin
         if (!WEN_EVEN) mem_even[A_EVEN] <= D;
         else           Q_EVEN <= mem_even[A_EVEN];
      end
      if (!CEN_ODD) begin
         if (!WEN_ODD) mem_odd[A_ODD] <= D;
         else          Q_ODD <= mem_odd[A_ODD];
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // model state
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] wr_q[$];
   int  wr_n = 0, rd_n = 0, reads_reg = 0, pops = 0;
   bit  unread [2][DP];
   int  cyc = 0;
   // per-test observation counters, cleared by the stimulus
   int  acc_cnt = 0, edge16 = 0, first_valid_edge = 0, even_rd_cnt = 0, pops_test = 0;
   int  even_wr = 0, odd_wr = 0, wr_wraps = 0;
   bit  first_valid_seen = 0, overlap_seen = 0, first_wr_seen = 0;
   int  first_wr_bank = -1, first_wr_addr = -1;
   int  last_wr_a [2] = '{0, 0};

   always @(posedge CLK) cyc++;

   task automatic model_write(input int bank, input int addr);
      logic [DW-1:0] w;
      chk("wr_bank", bank, (wr_n / DP) % 2);
      chk("wr_addr", addr, wr_n % DP);
      if (wr_q.size() == 0) begin
         chk("wr_unexpected", 1, 0);
      end else begin
         w = wr_q.pop_front();
         chk("wr_data", D, w);
      end
      chk("wr_overwrites_unread", unread[bank][addr], 0);
      unread[bank][addr] = 1;
      if (addr == 0 && last_wr_a[bank] == DP - 1) wr_wraps++;
      last_wr_a[bank] = addr;
      if (bank == 0) even_wr++; else odd_wr++;
      if (!first_wr_seen) begin
         first_wr_seen = 1;
         first_wr_bank = bank;
         first_wr_addr = addr;
      end
      wr_n++;
   endtask

   task automatic model_read(input int bank, input int addr);
      chk("rd_bank", bank, (rd_n / DP) % 2);
      chk("rd_addr", addr, rd_n % DP);
      chk("rd_of_unwritten", unread[bank][addr], 1);
      unread[bank][addr] = 0;
      if (bank == 0) even_rd_cnt++;
      rd_n++;
      reads_reg++;
   endtask

   // compare process: pins seen here were registered at the preceding rising edge
   always @(negedge CLK) begin
      if (!RESET_N) begin
         chk("rst_pins", {CEN_EVEN, WEN_EVEN, CEN_ODD, WEN_ODD, A_EVEN, A_ODD, out_valid},
             {4'b1111, 8'h00, 1'b0});
         chk("rst_data", {D, out_data}, '0);
         exp_q.delete();
         wr_q.delete();
         wr_n = 0; rd_n = 0; reads_reg = 0; pops = 0;
         for (int b = 0; b < 2; b++)
            for (int a = 0; a < DP; a++) unread[b][a] = 0;
      end else begin
         if (!CEN_EVEN && !WEN_EVEN) model_write(0, int'(A_EVEN));
         if (!CEN_ODD  && !WEN_ODD)  model_write(1, int'(A_ODD));
         if (!CEN_EVEN &&  WEN_EVEN) model_read(0, int'(A_EVEN));
         if (!CEN_ODD  &&  WEN_ODD)  model_read(1, int'(A_ODD));
         if (!CEN_ODD && !WEN_ODD && !CEN_EVEN && WEN_EVEN) overlap_seen = 1;
         chk("fifo_bound", ((reads_reg - pops) <= FD), 1);
         if (out_valid) begin
            if (!first_valid_seen) begin
               first_valid_seen = 1;
               first_valid_edge = cyc;
            end
            if (exp_q.size() == 0) chk("out_spurious", 1, 0);
            else begin
               chk("out_data", out_data, exp_q[0]);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  pops++;
                  pops_test++;
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
            wr_q.push_back(in_data);
            acc_cnt++;
            if (acc_cnt == DP) edge16 = cyc + 1;
         end
      end
   end

   task automatic clear_obs();
      acc_cnt = 0; edge16 = 0; first_valid_edge = 0; even_rd_cnt = 0; pops_test = 0;
      even_wr = 0; odd_wr = 0; wr_wraps = 0;
      first_valid_seen = 0; overlap_seen = 0;
   endtask

   // drives words base.. until n are accepted or max_cyc elapse; returns on a rising edge
   task automatic stream(input logic [DW-1:0] base, input int n, input int vpct, input int rpct,
                         input int max_cyc, output int acc, output int stalls);
      int  idx = 0;
      bit  taken;
      stalls = 0;
      for (int c = 0; c < max_cyc && idx < n; c++) begin
         #1;
         in_valid  = ($urandom_range(99) < vpct);
         in_data   = base + DW'(idx);
         out_ready = ($urandom_range(99) < rpct);
         @(negedge CLK);
         if (in_valid && !in_ready) stalls++;
         taken = in_valid && in_ready;
         @(posedge CLK);
         if (taken) idx++;
      end
      acc = idx;
   endtask

   task automatic drain(input int keep, input int max_cyc);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < max_cyc; c++) begin
         @(posedge CLK);
         if (exp_q.size() <= keep) break;
      end
      chk("drain_left", exp_q.size(), keep);
   endtask

   int acc, stalls;

   initial begin
      repeat (3) @(posedge CLK);
      #1 RESET_N = 1'b1;
      @(negedge CLK);
      chk("in_ready_after_reset", in_ready, 1);
      chk("out_valid_after_reset", out_valid, 0);
      @(posedge CLK);

      // full-rate stream of 32 words
      clear_obs();
      stream(32'h0, 32, 100, 100, 100, acc, stalls);
      chk("t1_accepted", acc, 32);
      chk("t1_stalls", stalls, 0);
      drain(0, 100);
      chk("t1_latency", first_valid_edge - edge16, 3);
      chk("t1_overlap", overlap_seen, 1);
      chk("t1_pops", pops_test, 32);

      // consumer blocked: both banks fill, FIFO holds four words
      clear_obs();
      stream(32'h0, 40, 100, 0, 60, acc, stalls);
      #1 in_valid = 1'b0;
      @(negedge CLK);
      chk("t2_accepted", acc, 32);
      chk("t2_in_ready", in_ready, 0);
      chk("t2_out_valid", out_valid, 1);
      chk("t2_head", out_data, 32'h0);
      chk("t2_even_reads", even_rd_cnt, 4);
      chk("t2_queued", exp_q.size(), 32);
      @(posedge CLK);
      drain(0, 200);
      chk("t2_pops", pops_test, 32);

      // 64 words: each bank used twice, addresses wrap
      clear_obs();
      stream(32'h40, 64, 100, 100, 200, acc, stalls);
      chk("t3_accepted", acc, 64);
      drain(0, 100);
      chk("t3_even_writes", even_wr, 32);
      chk("t3_odd_writes", odd_wr, 32);
      chk("t3_wraps", wr_wraps, 4);

      // randomised handshakes; last 8 words sit in a partial bank
      clear_obs();
      stream(32'h1000, 200, 50, 50, 3000, acc, stalls);
      chk("t4_accepted", acc, 200);
      drain(8, 400);
      repeat (20) @(posedge CLK);
      chk("t4_partial_kept", exp_q.size(), 8);
      chk("t4_no_out", out_valid, 0);

      // reset mid-stream with reads in flight
      clear_obs();
      stream(32'h2000, 20, 100, 100, 100, acc, stalls);
      chk("t5_accepted", acc, 20);
      #1 in_valid = 1'b0;
      #2 RESET_N = 1'b0;
      #1;
      chk("t5_rst_pins", {CEN_EVEN, WEN_EVEN, CEN_ODD, WEN_ODD, A_EVEN, A_ODD}, {4'b1111, 8'h00});
      chk("t5_rst_out", {out_valid, out_data, D}, '0);
      repeat (3) @(posedge CLK);
      #1 RESET_N = 1'b1;
      first_wr_seen = 0;
      clear_obs();
      @(posedge CLK);
      stream(32'h100, 16, 100, 100, 100, acc, stalls);
      chk("t5_post_accepted", acc, 16);
      drain(0, 100);
      chk("t5_first_wr_bank", first_wr_bank, 0);
      chk("t5_first_wr_addr", first_wr_addr, 0);
      chk("t5_pops", pops_test, 16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog expired at %0t", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
